// File: rtl/rvh_l1d_line_refill_issuer_if.sv
// Handshake bundle between the miss-line FIFO, the memory read port and the bank refill path.
// Latency: none, wires only.
// Backpressure: valid/ready on each of the line, request, response and refill channels.
interface rvh_l1d_line_refill_issuer_if #(
    parameter int LINE_ADDR_W    = 32,
    parameter int LINE_OFFSET_W  = 6,
    parameter int BEATS_PER_LINE = 4,
    parameter int BEAT_DATA_W    = 128,
    parameter int ID_W           = 4
);
    logic                                  flush_i;
    logic                                  line_vld_i;
    logic [LINE_ADDR_W-1:0]                line_addr_i;
    logic                                  line_rdy_o;
    logic                                  mem_req_vld_o;
    logic                                  mem_req_rdy_i;
    logic [LINE_ADDR_W+LINE_OFFSET_W-1:0]  mem_req_addr_o;
    logic [ID_W-1:0]                       mem_req_id_o;
    logic                                  mem_resp_vld_i;
    logic                                  mem_resp_rdy_o;
    logic [ID_W-1:0]                       mem_resp_id_i;
    logic [BEAT_DATA_W-1:0]                mem_resp_data_i;
    logic                                  mem_resp_last_i;
    logic                                  mem_resp_err_i;
    logic                                  refill_vld_o;
    logic                                  refill_rdy_i;
    logic [LINE_ADDR_W-1:0]                refill_line_addr_o;
    logic [BEATS_PER_LINE*BEAT_DATA_W-1:0] refill_data_o;
    logic                                  refill_err_o;
    logic                                  busy_o;

    modport slave (
        input  flush_i, line_vld_i, line_addr_i, mem_req_rdy_i,
               mem_resp_vld_i, mem_resp_id_i, mem_resp_data_i, mem_resp_last_i, mem_resp_err_i,
               refill_rdy_i,
        output line_rdy_o, mem_req_vld_o, mem_req_addr_o, mem_req_id_o, mem_resp_rdy_o,
               refill_vld_o, refill_line_addr_o, refill_data_o, refill_err_o, busy_o
    );

    modport master (
        output flush_i, line_vld_i, line_addr_i, mem_req_rdy_i,
               mem_resp_vld_i, mem_resp_id_i, mem_resp_data_i, mem_resp_last_i, mem_resp_err_i,
               refill_rdy_i,
        input  line_rdy_o, mem_req_vld_o, mem_req_addr_o, mem_req_id_o, mem_resp_rdy_o,
               refill_vld_o, refill_line_addr_o, refill_data_o, refill_err_o, busy_o
    );
endinterface

// File: rtl/rvh_l1d_line_refill_issuer.sv
// Serial L1D line refill: pop line, one read request, gather beats, present line. Option: RVH_L1D_REFILL_TIMEOUT_EN.
// Latency: request valid 1 cycle after pop; refill valid 1 cycle after the final matching beat.
// Backpressure: request/address/ID and refill line held until accepted; response beats always accepted in RESP.
module rvh_l1d_line_refill_issuer #(
    parameter int LINE_ADDR_W    = 32,
    parameter int LINE_OFFSET_W  = 6,
    parameter int BEATS_PER_LINE = 4,
    parameter int BEAT_DATA_W    = 128,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    rvh_l1d_line_refill_issuer_if.slave bus
);
    localparam int CNT_W = $clog2(BEATS_PER_LINE);

    if (BEATS_PER_LINE < 2 || (BEATS_PER_LINE & (BEATS_PER_LINE - 1)) != 0 || TIMEOUT_CYCLES < 2)
    begin : g_param_check
        $error("rvh_l1d_line_refill_issuer: illegal BEATS_PER_LINE or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

    state_t                                     state, state_nxt;
    logic [LINE_ADDR_W-1:0]                     addr_q;
    logic [CNT_W-1:0]                           beat_cnt;
    logic [ID_W-1:0]                            id_cnt;
    logic                                       drain;
    logic                                       err;
    logic [BEATS_PER_LINE-1:0][BEAT_DATA_W-1:0] line_buf;

    logic line_rdy, req_vld, resp_rdy, refill_vld;
    logic line_fire, req_fire, beat_match, beat_is_last, beat_final, last_bad, timeout;

    assign line_fire    = bus.line_vld_i && bus.line_rdy_o;
    assign req_fire     = req_vld && bus.mem_req_rdy_i;
    assign beat_match   = (state == RESP) && bus.mem_resp_vld_i && (bus.mem_resp_id_i == id_cnt);
    assign beat_is_last = (beat_cnt == CNT_W'(BEATS_PER_LINE - 1));
    assign beat_final   = beat_match && beat_is_last;
    // The beat counter, not the last flag, decides completion; a misplaced flag only poisons the line.
    assign last_bad     = (bus.mem_resp_last_i != beat_is_last);

`ifdef RVH_L1D_REFILL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (!rst || state != RESP || beat_match) to_cnt <= '0;
        else                                     to_cnt <= to_cnt + TO_W'(1);
    end

    assign timeout = (state == RESP) && !beat_match && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        line_rdy   = 1'b0;
        req_vld    = 1'b0;
        resp_rdy   = 1'b0;
        refill_vld = 1'b0;
        case (state)
            IDLE: begin
                line_rdy = !bus.flush_i;
                if (bus.line_vld_i && !bus.flush_i) state_nxt = REQ;
            end
            REQ: begin
                req_vld = 1'b1;
                if (bus.mem_req_rdy_i) state_nxt = RESP;
                else if (bus.flush_i)  state_nxt = IDLE;
            end
            RESP: begin
                resp_rdy = 1'b1;
                if (beat_final || timeout) state_nxt = (drain || bus.flush_i) ? IDLE : OUT;
            end
            OUT: begin
                refill_vld = 1'b1;
                if (bus.refill_rdy_i || bus.flush_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_cnt <= '0;
            id_cnt   <= '0;
            drain    <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (line_fire) err <= 1'b0;
                REQ:  if (req_fire)  drain <= bus.flush_i;
                RESP: begin
                    if (bus.flush_i) drain <= 1'b1;
                    if (beat_match) begin
                        err      <= err | bus.mem_resp_err_i | last_bad;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_final) begin
                            id_cnt <= id_cnt + ID_W'(1);
                            drain  <= 1'b0;
                        end
                    end else if (timeout) begin
                        // Retire the ID so any late beats of this line fail the ID match.
                        err      <= 1'b1;
                        id_cnt   <= id_cnt + ID_W'(1);
                        beat_cnt <= '0;
                        drain    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (line_fire)  addr_q             <= bus.line_addr_i;
        if (beat_match) line_buf[beat_cnt] <= bus.mem_resp_data_i;
    end

    assign bus.line_rdy_o         = rst && line_rdy;
    assign bus.mem_req_vld_o      = rst && req_vld;
    assign bus.mem_resp_rdy_o     = rst && resp_rdy;
    assign bus.refill_vld_o       = rst && refill_vld;
    assign bus.mem_req_addr_o     = {addr_q, {LINE_OFFSET_W{1'b0}}};
    assign bus.mem_req_id_o       = rst ? id_cnt : '0;
    assign bus.refill_line_addr_o = addr_q;
    assign bus.refill_data_o      = line_buf;
    assign bus.refill_err_o       = err;
    assign bus.busy_o             = (state != IDLE);
endmodule

// File: tb/tb_rvh_l1d_line_refill_issuer.sv
// Bench for rvh_l1d_line_refill_issuer: cycle vector table, directed corner sequences,
// and randomized lines checked against a transaction-level line model.
module tb_rvh_l1d_line_refill_issuer;
    localparam int LA  = 32;
    localparam int OFF = 6;
    localparam int BPL = 4;
    localparam int BDW = 128;
    localparam int IDW = 4;
`ifdef RVH_L1D_REFILL_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 1024;
`endif

    logic clk;
    logic rst;

    rvh_l1d_line_refill_issuer_if #(
        .LINE_ADDR_W(LA), .LINE_OFFSET_W(OFF), .BEATS_PER_LINE(BPL), .BEAT_DATA_W(BDW), .ID_W(IDW)
    ) bus ();

    rvh_l1d_line_refill_issuer #(
        .LINE_ADDR_W(LA), .LINE_OFFSET_W(OFF), .BEATS_PER_LINE(BPL), .BEAT_DATA_W(BDW), .ID_W(IDW),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pops = 0;
    int req_fires = 0;
    int refill_fires = 0;
    int refill_vld_cycles = 0;

    logic [IDW-1:0]     model_id;
    logic [BPL*BDW-1:0] exp_d;

    always @(posedge clk) begin
        if (bus.line_vld_i && bus.line_rdy_o)      pops++;
        if (bus.mem_req_vld_o && bus.mem_req_rdy_i) req_fires++;
        if (bus.refill_vld_o && bus.refill_rdy_i)  refill_fires++;
        if (bus.refill_vld_o)                      refill_vld_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.flush_i = 0; bus.line_vld_i = 0; bus.line_addr_i = '0; bus.mem_req_rdy_i = 0;
        bus.mem_resp_vld_i = 0; bus.mem_resp_id_i = '0; bus.mem_resp_data_i = '0;
        bus.mem_resp_last_i = 0; bus.mem_resp_err_i = 0; bus.refill_rdy_i = 0;
    endtask

    task automatic pop_line(input logic [LA-1:0] a);
        bus.line_addr_i = a;
        bus.line_vld_i  = 1;
        #1;
        for (int n = 0; n < 50 && !bus.line_rdy_o; n++) tick();
        chk("line_rdy", bus.line_rdy_o, 1);
        tick();
        bus.line_vld_i = 0;
        #1;
        chk("req_vld_after_pop", bus.mem_req_vld_o, 1);
    endtask

    task automatic do_req(input logic [LA-1:0] a, input int stall);
        for (int n = 0; n < 50 && !bus.mem_req_vld_o; n++) tick();
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) begin
                bus.mem_req_rdy_i = 1;
                #1;
            end
            chk("req_vld", bus.mem_req_vld_o, 1);
            chk("req_addr", bus.mem_req_addr_o, {a, {OFF{1'b0}}});
            chk("req_id", bus.mem_req_id_o, model_id);
            if (i < stall) tick();
        end
        tick();
        bus.mem_req_rdy_i = 0;
        #1;
    endtask

    task automatic beat(input logic [IDW-1:0] id, input logic [BDW-1:0] d, input logic last, input logic e);
        bus.mem_resp_vld_i = 1; bus.mem_resp_id_i = id; bus.mem_resp_data_i = d;
        bus.mem_resp_last_i = last; bus.mem_resp_err_i = e;
        #1;
        for (int n = 0; n < 50 && !bus.mem_resp_rdy_o; n++) tick();
        chk("resp_rdy", bus.mem_resp_rdy_o, 1);
        tick();
        bus.mem_resp_vld_i = 0;
        #1;
    endtask

    task automatic take_refill(input logic [LA-1:0] a, input logic [BPL*BDW-1:0] d, input logic e, input int stall);
        for (int n = 0; n < 50 && !bus.refill_vld_o; n++) tick();
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) begin
                bus.refill_rdy_i = 1;
                #1;
            end
            chk("refill_vld", bus.refill_vld_o, 1);
            chk("refill_addr", bus.refill_line_addr_o, a);
            chk("refill_data", bus.refill_data_o, d);
            chk("refill_err", bus.refill_err_o, e);
            if (i < stall) tick();
        end
        tick();
        bus.refill_rdy_i = 0;
        #1;
        chk("busy_after_refill", bus.busy_o, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // in  = {flush, line_vld, req_rdy, resp_vld, resp_last, refill_rdy}
    // exp = {line_rdy, req_vld, resp_rdy, refill_vld, busy}
    typedef struct packed {
        logic [5:0] in;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int p0, q0, r0, v0;
        logic [LA-1:0] a;
        logic [BDW-1:0] d;
        logic last, e, exp_e;

        tbl[0]  = '{6'b110000, 5'b00000};
        tbl[1]  = '{6'b000000, 5'b10000};
        tbl[2]  = '{6'b010000, 5'b10000};
        tbl[3]  = '{6'b000000, 5'b01001};
        tbl[4]  = '{6'b100000, 5'b01001};
        tbl[5]  = '{6'b000000, 5'b10000};
        tbl[6]  = '{6'b010000, 5'b10000};
        tbl[7]  = '{6'b101000, 5'b01001};
        tbl[8]  = '{6'b000100, 5'b00101};
        tbl[9]  = '{6'b000100, 5'b00101};
        tbl[10] = '{6'b000100, 5'b00101};
        tbl[11] = '{6'b000110, 5'b00101};
        tbl[12] = '{6'b000000, 5'b10000};

        // Reset state, with a line waiting at the FIFO head.
        clr_in();
        rst = 0;
        bus.line_vld_i = 1;
        idle_cycles(3);
        chk("rst_line_rdy", bus.line_rdy_o, 0);
        chk("rst_req_vld", bus.mem_req_vld_o, 0);
        chk("rst_resp_rdy", bus.mem_resp_rdy_o, 0);
        chk("rst_refill_vld", bus.refill_vld_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_req_id", bus.mem_req_id_o, 0);
        chk("rst_pops", pops, 0);
        bus.line_vld_i = 0;
        rst = 1;
        #1;
        chk("post_rst_line_rdy", bus.line_rdy_o, 1);
        model_id = '0;

        // Basic line: address 0x1234, beats A..D.
        pop_line(32'h1234);
        chk("s1_addr_const", bus.mem_req_addr_o, 38'h48D00);
        do_req(32'h1234, 0);
        for (int k = 0; k < BPL; k++) beat(model_id, BDW'(k + 10), k == BPL - 1, 0);
        exp_d = {128'hD, 128'hC, 128'hB, 128'hA};
        take_refill(32'h1234, exp_d, 0, 0);
        model_id = model_id + 1'b1;
        tick();

        // Cycle table: flush blocks pop, flush in REQ with/without fire, drained line.
        q0 = req_fires; v0 = refill_vld_cycles;
        bus.line_addr_i = 32'hABC;
        for (int i = 0; i < 13; i++) begin
            {bus.flush_i, bus.line_vld_i, bus.mem_req_rdy_i, bus.mem_resp_vld_i,
             bus.mem_resp_last_i, bus.refill_rdy_i} = tbl[i].in;
            bus.mem_resp_id_i = model_id;
            #1;
            chk($sformatf("vec%0d", i),
                {bus.line_rdy_o, bus.mem_req_vld_o, bus.mem_resp_rdy_o, bus.refill_vld_o, bus.busy_o},
                tbl[i].exp);
            tick();
        end
        clr_in();
        chk("tbl_req_fires", req_fires - q0, 1);
        chk("tbl_no_refill", refill_vld_cycles - v0, 0);
        model_id = model_id + 1'b1;

        // Request held off 5 cycles.
        p0 = pops; q0 = req_fires;
        pop_line(32'h00C0FFEE);
        do_req(32'h00C0FFEE, 5);
        for (int k = 0; k < BPL; k++) beat(model_id, BDW'(k + 100), k == BPL - 1, 0);
        exp_d = {128'd103, 128'd102, 128'd101, 128'd100};
        take_refill(32'h00C0FFEE, exp_d, 0, 1);
        chk("stall_one_pop", pops - p0, 1);
        chk("stall_one_req", req_fires - q0, 1);
        model_id = model_id + 1'b1;
        tick();

        // Foreign ID beat and an error beat.
        pop_line(32'h77);
        do_req(32'h77, 0);
        beat(model_id, 128'h11, 0, 0);
        beat(model_id, 128'h22, 0, 0);
        beat(4'd7, 128'hDEAD, 0, 0);
        beat(model_id, 128'h33, 0, 1);
        beat(model_id, 128'h44, 1, 0);
        exp_d = {128'h44, 128'h33, 128'h22, 128'h11};
        take_refill(32'h77, exp_d, 1, 0);
        model_id = model_id + 1'b1;
        tick();

        // Flush during RESP after two beats.
        v0 = refill_vld_cycles;
        pop_line(32'h99);
        do_req(32'h99, 0);
        beat(model_id, 128'h1, 0, 0);
        beat(model_id, 128'h2, 0, 0);
        bus.flush_i = 1;
        #1;
        chk("flush_resp_rdy", bus.mem_resp_rdy_o, 1);
        tick();
        bus.flush_i = 0;
        beat(model_id, 128'h3, 0, 0);
        beat(model_id, 128'h4, 1, 0);
        chk("flush_busy", bus.busy_o, 0);
        chk("flush_no_refill", refill_vld_cycles - v0, 0);
        model_id = model_id + 1'b1;

        // Reset pulse while a line waits in OUT.
        pop_line(32'h1111);
        do_req(32'h1111, 0);
        for (int k = 0; k < BPL; k++) beat(model_id, BDW'(k), k == BPL - 1, 0);
        for (int n = 0; n < 50 && !bus.refill_vld_o; n++) tick();
        chk("rst_out_reached", bus.refill_vld_o, 1);
        p0 = pops; r0 = refill_fires;
        bus.line_addr_i = 32'h55;
        bus.line_vld_i = 1;
        rst = 0;
        #1;
        chk("rst_out_line_rdy", bus.line_rdy_o, 0);
        tick();
        chk("rst_out_refill_vld", bus.refill_vld_o, 0);
        chk("rst_out_busy", bus.busy_o, 0);
        chk("rst_out_req_id", bus.mem_req_id_o, 0);
        tick();
        chk("rst_out_no_pop", pops - p0, 0);
        chk("rst_out_no_refill", refill_fires - r0, 0);
        rst = 1;
        model_id = '0;
        pop_line(32'h55);
        do_req(32'h55, 0);
        for (int k = 0; k < BPL; k++) beat(model_id, BDW'(k + 5), k == BPL - 1, 0);
        exp_d = {128'd8, 128'd7, 128'd6, 128'd5};
        take_refill(32'h55, exp_d, 0, 0);
        model_id = model_id + 1'b1;

        // Randomized lines against the line model.
        for (int l = 0; l < 25; l++) begin
            a = $urandom;
            idle_cycles($urandom_range(1, 2));
            pop_line(a);
            do_req(a, $urandom_range(0, 3));
            exp_e = 0;
            for (int k = 0; k < BPL; k++) begin
                if ($urandom_range(0, 3) == 0)
                    beat(model_id + IDW'($urandom_range(1, 15)),
                         {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom));
                idle_cycles($urandom_range(0, 2));
                d = {$urandom, $urandom, $urandom, $urandom};
                e = ($urandom_range(0, 7) == 0);
                last = (k == BPL - 1);
                if ($urandom_range(0, 9) == 0) last = !last;
                exp_e = exp_e | e | (last != (k == BPL - 1));
                exp_d[k*BDW +: BDW] = d;
                beat(model_id, d, last, e);
            end
            take_refill(a, exp_d, exp_e, $urandom_range(0, 3));
            model_id = model_id + 1'b1;
        end

`ifdef RVH_L1D_REFILL_TIMEOUT_EN
        begin
            int waited;
            logic [IDW-1:0] old_id;
            tick();
            pop_line(32'h2222);
            do_req(32'h2222, 0);
            waited = 0;
            for (int n = 0; n < 50 && !bus.refill_vld_o; n++) begin
                tick();
                waited++;
            end
            chk("to_cycles", waited, TO_CYC);
            chk("to_err", bus.refill_err_o, 1);
            chk("to_vld", bus.refill_vld_o, 1);
            bus.refill_rdy_i = 1;
            tick();
            bus.refill_rdy_i = 0;
            old_id = model_id;
            model_id = model_id + 1'b1;
            tick();
            pop_line(32'h3333);
            do_req(32'h3333, 0);
            beat(old_id, 128'hBAD, 0, 1);
            for (int k = 0; k < BPL; k++) beat(model_id, BDW'(k + 20), k == BPL - 1, 0);
            exp_d = {128'd23, 128'd22, 128'd21, 128'd20};
            take_refill(32'h3333, exp_d, 0, 0);
            model_id = model_id + 1'b1;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rvh_l1d_line_refill_issuer.md
Name: rvh_l1d_line_refill_issuer

Overview:
- Sits directly downstream of the L1D bank miss-line-address FIFO. It pops one line address at a time through a valid/ready handshake.
- Issues one memory read request per line, collects BEATS_PER_LINE response beats into a line buffer, and presents the assembled line to the bank refill path.
- One request outstanding at a time; the block is strictly serial.

Parameters:
- LINE_ADDR_W, 32, width of the line address (matches the FIFO payload width).
- LINE_OFFSET_W, 6, byte-offset bits appended as zeros to form the request byte address.
- BEATS_PER_LINE, 4, response beats per line (power of two, at least 2).
- BEAT_DATA_W, 128, data bits per beat.
- ID_W, 4, transaction ID width.
- TIMEOUT_CYCLES, 1024, response watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (0 = reset).
- flush_i  in  1  abandon current line.
- line_vld_i  in  1  FIFO has a line address.
- line_addr_i  in  LINE_ADDR_W  head line address.
- line_rdy_o  out  1  pop FIFO head.
- mem_req_vld_o  out  1  read request valid.
- mem_req_rdy_i  in  1  memory accepts request.
- mem_req_addr_o  out  LINE_ADDR_W+LINE_OFFSET_W  byte address = {line_addr, zeros}.
- mem_req_id_o  out  ID_W  request ID.
- mem_resp_vld_i  in  1  response beat valid.
- mem_resp_rdy_o  out  1  beat accepted.
- mem_resp_id_i  in  ID_W  beat ID.
- mem_resp_data_i  in  BEAT_DATA_W  beat data.
- mem_resp_last_i  in  1  final beat flag.
- mem_resp_err_i  in  1  beat error.
- refill_vld_o  out  1  assembled line valid.
- refill_rdy_i  in  1  refill path accepts.
- refill_line_addr_o  out  LINE_ADDR_W  line address.
- refill_data_o  out  BEATS_PER_LINE*BEAT_DATA_W  line data; beat k occupies slice k.
- refill_err_o  out  1  any beat error or protocol error.
- busy_o  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, REQ, RESP, OUT.
- Reset (rst==0): state IDLE, beat counter 0, ID counter 0, drain flag 0, error flag 0, line buffer not cleared.
  - All valid/ready outputs are 0 during reset.
  - mem_req_id_o=0.
- IDLE:
  - line_rdy_o = !flush_i. When flush_i is asserted, flush wins and no pop occurs.
  - On line fire: capture the address, clear the error flag, and go to REQ. Request valid appears 1 cycle after the pop.
- REQ:
  - mem_req_vld_o=1. Address and ID are held stable until mem_req_rdy_i.
  - On fire: go to RESP.
  - flush_i without fire: go to IDLE with no request sent.
  - flush_i together with fire: go to RESP with the drain flag set.
- RESP:
  - mem_resp_rdy_o=1.
  - Beat with matching ID: write data to slice[beat counter], OR its error into the error flag, increment the counter.
  - Beat with non-matching ID: accepted and discarded; counter and error flag unchanged.
  - mem_resp_last_i must be 1 exactly on beat BEATS_PER_LINE-1. Any mismatch sets the error flag, and the counter still decides completion.
  - On the final matching beat: counter wraps to 0 and the ID counter increments (wraps modulo 2^ID_W). Then go to IDLE if the drain flag is set (clear it), otherwise go to OUT.
  - flush_i in RESP: set the drain flag. Beats continue to be consumed; no refill is produced.
- OUT:
  - refill_vld_o=1. Address, data and error are held stable until refill_rdy_i; then go to IDLE.
  - flush_i in OUT: drop the line, go to IDLE next cycle with refill_vld_o deasserted.
  - A same-cycle refill_rdy_i still counts as delivered.
- No combinational path from line_vld_i to any memory output. Back-to-back lines need at least 1 idle cycle between refill fire and the next pop.

Optional Feature:
- Macro: RVH_L1D_REFILL_TIMEOUT_EN.
- With it defined:
  - A counter clears on entry to RESP and on each matching beat, and increments in every other RESP cycle.
  - On reaching TIMEOUT_CYCLES-1: set the error flag, increment the ID counter, clear the beat counter. Then go to OUT, or to IDLE if draining.
  - Stale beats that arrive later are discarded by the ID mismatch rule.
- Without it: RESP waits indefinitely and no counter logic is present.

Test Plan:
- Line 0x1234 popped, mem_req_rdy_i=1 immediately, 4 beats with ID 0, data 0xA..0xD, last on beat 3 → mem_req_addr_o=0x48D00; refill_data_o slices 0..3 = A,B,C,D; refill_err_o=0; next request ID=1.
- mem_req_rdy_i held low 5 cycles → mem_req_vld_o/addr/id stable for 6 cycles; exactly one request fire; exactly one FIFO pop.
- Beat with ID 7 injected between matching beats 1 and 2, and mem_resp_err_i=1 on beat 2 → ID-7 beat dropped; slices correct; refill_err_o=1.
- flush_i in RESP after beat 1 → remaining 2 beats consumed; no refill_vld_o; back in IDLE; next line gets ID+1.
- Reset (rst=0) pulsed in OUT with refill_rdy_i=0 → next cycle refill_vld_o=0, busy_o=0, mem_req_id_o=0; FIFO head not popped again until rst=1.
- With RVH_L1D_REFILL_TIMEOUT_EN, TIMEOUT_CYCLES=8, no beats → refill_vld_o with refill_err_o=1 after 8 RESP cycles; late beats with the old ID discarded.
